// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: one 32-bit word per line, 1-cycle hit latency,
// single outstanding word read to the RAM controller on a miss.
module icache_direct #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  fetch_en_in,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_in,
    input  logic                  flush_in,
    output logic                  fetch_rdy_out,
    output logic [INST_WIDTH-1:0] fetch_inst_out,
    output logic                  mem_en_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic                  mem_rdy_in,
    input  logic [INST_WIDTH-1:0] mem_inst_in
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t                state_q;
    logic                  abort_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [INST_WIDTH-1:0] data_q [LINES];

    logic [INDEX_BITS-1:0] fetch_index;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  hit;
    logic                  accept;
    logic                  fill;
    logic                  unused_addr_bits;

    assign fetch_index = fetch_addr_in[INDEX_BITS+1:2];
    assign fetch_tag   = fetch_addr_in[ADDR_WIDTH-1:INDEX_BITS+2];

    // The held miss address doubles as the fill index/tag, so no extra register is needed.
    assign miss_index  = mem_addr_out[INDEX_BITS+1:2];
    assign miss_tag    = mem_addr_out[ADDR_WIDTH-1:INDEX_BITS+2];

    assign hit    = valid_q[fetch_index] && (tag_q[fetch_index] == fetch_tag);
    assign accept = (state_q == IDLE) && fetch_en_in && !flush_in && !fetch_rdy_out;
    assign fill   = (state_q == MISS) && mem_rdy_in;

    assign unused_addr_bits = ^{fetch_addr_in[1:0], mem_addr_out[1:0]};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= IDLE;
            abort_q        <= 1'b0;
            valid_q        <= '0;
            fetch_rdy_out  <= 1'b0;
            fetch_inst_out <= '0;
            mem_en_out     <= 1'b0;
            mem_addr_out   <= '0;
        end else if (rdy_in) begin
            fetch_rdy_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            fetch_rdy_out  <= 1'b1;
                            fetch_inst_out <= data_q[fetch_index];
                        end else begin
                            state_q      <= MISS;
                            mem_en_out   <= 1'b1;
                            mem_addr_out <= {fetch_addr_in[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                MISS: begin
                    if (mem_rdy_in) begin
                        valid_q[miss_index] <= 1'b1;
                        mem_en_out          <= 1'b0;
                        state_q             <= IDLE;
                        abort_q             <= 1'b0;
                        // A flush arriving with the data still fills the line but must not answer.
                        if (!abort_q && !flush_in) begin
                            fetch_rdy_out  <= 1'b1;
                            fetch_inst_out <= mem_inst_in;
                        end
                    end else if (flush_in) begin
                        abort_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill) begin
            tag_q[miss_index]  <= miss_tag;
            data_q[miss_index] <= mem_inst_in;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct; the RAM controller response is
// driven by hand in each step.
module tb_icache_direct;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        fetch_en_in;
    logic [31:0] fetch_addr_in;
    logic        flush_in;
    logic        fetch_rdy_out;
    logic [31:0] fetch_inst_out;
    logic        mem_en_out;
    logic [31:0] mem_addr_out;
    logic        mem_rdy_in;
    logic [31:0] mem_inst_in;

    int errors = 0;
    int checks = 0;

    icache_direct #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .INDEX_BITS(6)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .fetch_en_in   (fetch_en_in),
        .fetch_addr_in (fetch_addr_in),
        .flush_in      (flush_in),
        .fetch_rdy_out (fetch_rdy_out),
        .fetch_inst_out(fetch_inst_out),
        .mem_en_out    (mem_en_out),
        .mem_addr_out  (mem_addr_out),
        .mem_rdy_in    (mem_rdy_in),
        .mem_inst_in   (mem_inst_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drives one cycle of inputs, then lets one rising edge pass.
    task automatic applyStimulus(input logic fe, input logic [31:0] fa, input logic fl,
                                 input logic mr, input logic [31:0] mi);
        fetch_en_in   = fe;
        fetch_addr_in = fa;
        flush_in      = fl;
        mem_rdy_in    = mr;
        mem_inst_in   = mi;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Miss on addr, answered by memory on the very next edge.
    task automatic fillLine(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 32'h0);
        checkOutput("fill_mem_en", {31'b0, mem_en_out}, 32'd1);
        checkOutput("fill_mem_addr", mem_addr_out, addr);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, data);
        checkOutput("fill_rdy", {31'b0, fetch_rdy_out}, 32'd1);
        checkOutput("fill_inst", fetch_inst_out, data);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    logic [31:0] seqData [4];

    initial begin
        rst_n_in      = 1'b0;
        rdy_in        = 1'b1;
        fetch_en_in   = 1'b0;
        fetch_addr_in = 32'h0;
        flush_in      = 1'b0;
        mem_rdy_in    = 1'b0;
        mem_inst_in   = 32'h0;
        seqData[0]    = 32'h0010_0093;
        seqData[1]    = 32'h0020_0113;
        seqData[2]    = 32'h0030_0193;
        seqData[3]    = 32'h0040_0213;

        tick();
        tick();
        checkOutput("reset_fetch_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        checkOutput("reset_fetch_inst", fetch_inst_out, 32'd0);
        checkOutput("reset_mem_en", {31'b0, mem_en_out}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr_out, 32'd0);
        rst_n_in = 1'b1;

        // Cold miss on 0x100, memory answers six cycles after the request.
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        checkOutput("cold_mem_en", {31'b0, mem_en_out}, 32'd1);
        checkOutput("cold_mem_addr", mem_addr_out, 32'h0000_0100);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
            checkOutput("cold_wait_mem_en", {31'b0, mem_en_out}, 32'd1);
            checkOutput("cold_wait_addr", mem_addr_out, 32'h0000_0100);
            checkOutput("cold_wait_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        end
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h0010_0093);
        checkOutput("cold_rdy", {31'b0, fetch_rdy_out}, 32'd1);
        checkOutput("cold_inst", fetch_inst_out, 32'h0010_0093);
        checkOutput("cold_mem_en_drop", {31'b0, mem_en_out}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("cold_rdy_pulse", {31'b0, fetch_rdy_out}, 32'd0);

        // Hit with low address bits set.
        applyStimulus(1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'h0);
        checkOutput("hit_rdy", {31'b0, fetch_rdy_out}, 32'd1);
        checkOutput("hit_inst", fetch_inst_out, 32'h0010_0093);
        checkOutput("hit_mem_en", {31'b0, mem_en_out}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("hit_rdy_pulse", {31'b0, fetch_rdy_out}, 32'd0);

        // Conflict: 0x200 evicts 0x100 from index 0.
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
        checkOutput("conf_mem_en", {31'b0, mem_en_out}, 32'd1);
        checkOutput("conf_mem_addr", mem_addr_out, 32'h0000_0200);
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("conf_rdy", {31'b0, fetch_rdy_out}, 32'd1);
        checkOutput("conf_inst", fetch_inst_out, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        checkOutput("conf_no_double_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        checkOutput("conf_no_double_mem", {31'b0, mem_en_out}, 32'd0);
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        checkOutput("conf_remiss_en", {31'b0, mem_en_out}, 32'd1);
        checkOutput("conf_remiss_addr", mem_addr_out, 32'h0000_0100);
        checkOutput("conf_remiss_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0010_0093);
        checkOutput("conf_refill_inst", fetch_inst_out, 32'h0010_0093);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Flush two cycles into a miss: line fills, no response.
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
        checkOutput("flush_mem_en", {31'b0, mem_en_out}, 32'd1);
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_hold_en", {31'b0, mem_en_out}, 32'd1);
        checkOutput("flush_hold_addr", mem_addr_out, 32'h0000_0300);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("flush_hold_en2", {31'b0, mem_en_out}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0300);
        checkOutput("flush_no_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        checkOutput("flush_mem_drop", {31'b0, mem_en_out}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("flush_no_rdy2", {31'b0, fetch_rdy_out}, 32'd0);
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
        checkOutput("flush_hit_rdy", {31'b0, fetch_rdy_out}, 32'd1);
        checkOutput("flush_hit_inst", fetch_inst_out, 32'hCAFE_0300);
        checkOutput("flush_hit_mem", {31'b0, mem_en_out}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Flush in IDLE drops a request that would have hit.
        applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0);
        checkOutput("idle_flush_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Stall during a miss with memory data offered, then async reset mid-cycle.
        applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_mem_en", {31'b0, mem_en_out}, 32'd1);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
            checkOutput("stall_hold_en", {31'b0, mem_en_out}, 32'd1);
            checkOutput("stall_hold_addr", mem_addr_out, 32'h0000_0400);
            checkOutput("stall_no_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        end
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("areset_mem_en", {31'b0, mem_en_out}, 32'd0);
        checkOutput("areset_mem_addr", mem_addr_out, 32'd0);
        checkOutput("areset_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        tick();
        rst_n_in = 1'b1;
        rdy_in   = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_2222);
        checkOutput("post_reset_ignore_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        checkOutput("post_reset_ignore_en", {31'b0, mem_en_out}, 32'd0);
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
        checkOutput("post_reset_miss_en", {31'b0, mem_en_out}, 32'd1);
        checkOutput("post_reset_miss_addr", mem_addr_out, 32'h0000_0300);
        checkOutput("post_reset_miss_rdy", {31'b0, fetch_rdy_out}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_0300);
        checkOutput("post_reset_fill_rdy", {31'b0, fetch_rdy_out}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Pre-fill 0x100..0x10C, then stream them back-to-back.
        for (int i = 0; i < 4; i++) begin
            fillLine(32'h0000_0100 + 32'(4 * i), seqData[i]);
        end
        fetch_en_in   = 1'b1;
        fetch_addr_in = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("b2b_rdy", {31'b0, fetch_rdy_out}, 32'd1);
            checkOutput("b2b_inst", fetch_inst_out, seqData[i]);
            checkOutput("b2b_mem_en", {31'b0, mem_en_out}, 32'd0);
            if (i == 3) fetch_en_in = 1'b0;
            fetch_addr_in = fetch_addr_in + 32'd4;
            tick();
            checkOutput("b2b_gap", {31'b0, fetch_rdy_out}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the instruction fetcher and the RAM controller's instruction port.
- Serves 32-bit fetches from on-chip lines with 1-cycle hit latency.
- On a miss, issues one word read to the RAM controller and holds it until the controller returns the word, then fills the line.
- Supports a fetch flush so a mispredicted fetch never returns stale data to the fetcher.

Parameters:
ADDR_WIDTH, 32, byte address width (matches `AddressWidth)
INST_WIDTH, 32, instruction word width (matches `IDWidth)
INDEX_BITS, 6, log2 of line count (64 lines, one 4-byte word per line)

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_n_in  input  1  reset; one clock; reset is asynchronous and active-low
rdy_in  input  1  global enable; when 0 all state and outputs freeze
fetch_en_in  input  1  fetch request valid; held with address until fetch_rdy_out or flush_in
fetch_addr_in  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
flush_in  input  1  abort the outstanding fetch (pipeline redirect)
fetch_rdy_out  output  1  one-cycle pulse: fetch_inst_out valid
fetch_inst_out  output  INST_WIDTH  fetched instruction
mem_en_out  output  1  instruction read request to RAM controller (inst_en)
mem_addr_out  output  ADDR_WIDTH  word-aligned miss address (inst_addr)
mem_rdy_in  input  1  one-cycle pulse from RAM controller: mem_inst_in valid
mem_inst_in  input  INST_WIDTH  word read from RAM

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[ADDR_WIDTH-1:INDEX_BITS+2]
  - Arrays: valid[2^INDEX_BITS], tag, data.
- Reset (async, rst_n_in=0): state=IDLE, all valid bits 0, abort flag 0, fetch_rdy_out=0, fetch_inst_out=0, mem_en_out=0, mem_addr_out=0. Tag and data arrays are not reset.
- All outputs are registered.
- IDLE:
  - At a posedge with fetch_en_in=1, flush_in=0, fetch_rdy_out=0, the request is accepted.
  - Hit (valid & tag match): next cycle fetch_rdy_out=1, fetch_inst_out=data[index]; state stays IDLE.
  - Miss: state->MISS; next cycle mem_en_out=1, mem_addr_out={fetch_addr_in[ADDR_WIDTH-1:2],2'b00}.
- No double serve: fetch_en_in is ignored in any cycle where fetch_rdy_out=1, so a requester updating its address on the rdy edge is never served twice. Hit throughput is therefore 1 fetch per 2 cycles.
- MISS:
  - mem_en_out and mem_addr_out stay constant until the posedge where mem_rdy_in=1.
  - At that edge: write data=mem_inst_in, tag, valid=1 at the miss index; mem_en_out<=0; state->IDLE.
  - If the abort flag is 0: fetch_rdy_out<=1 and fetch_inst_out<=mem_inst_in.
  - If the abort flag is 1: fetch_rdy_out stays 0, and the abort flag is cleared.
- Miss latency = RAM controller latency + 1 cycle.
- mem_en_out falls the cycle after mem_rdy_in. The controller then spends one cycle in its completion stage before it samples inst_en again, so no spurious re-read occurs.
- flush_in:
  - In IDLE: the request in that cycle is dropped and any fetch_rdy_out pulse due next cycle is suppressed (forced 0).
  - In MISS: mem_en_out is NOT dropped, because the controller's transaction cannot be cancelled. The abort flag is set, the line is still filled, and no response is returned.
- flush_in and mem_rdy_in in the same cycle: fill happens, response suppressed, state->IDLE.
- New requests are not accepted in MISS; fetch_en_in is only re-examined in IDLE.
- rdy_in=0: no register changes, including valid bits and the abort flag. mem_en_out and mem_addr_out hold, and mem_rdy_in is not sampled; the controller is frozen by the same rdy_in.
- fetch_rdy_out is never high for two consecutive cycles.
- Reset during MISS: everything clears immediately and any later mem_rdy_in is ignored in IDLE. The RAM controller is reset by the same system reset.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch 0x0000_0100; RAM controller model returns 0x0010_0093 after 6 cycles.
  - Required response: mem_en_out=1 with addr 0x100 until mem_rdy_in; fetch_rdy_out pulses once with 0x0010_0093; valid[0] set.
- Hit:
  - Stimulus: refetch 0x0000_0102.
  - Required response: no mem_en_out; fetch_rdy_out the cycle after acceptance with 0x0010_0093.
- Conflict:
  - Stimulus: fetch 0x0000_0200 (same index 0, different tag); memory returns 0xDEAD_BEEF; then fetch 0x100 again.
  - Required response: 0x200 misses and returns 0xDEAD_BEEF; the following fetch of 0x100 misses again.
- Flush mid-miss:
  - Stimulus: miss on 0x0000_0300, flush_in pulsed 2 cycles later.
  - Required response: mem_en_out held until mem_rdy_in; no fetch_rdy_out; subsequent fetch of 0x300 hits.
- Stall and reset:
  - Stimulus: rdy_in=0 for 5 cycles during MISS with mem_rdy_in asserted.
  - Required response: no state change and no fill.
  - Stimulus: then assert rst_n_in=0 asynchronously mid-cycle.
  - Required response: mem_en_out and fetch_rdy_out drop immediately; all lines invalid afterwards.
- Back-to-back:
  - Stimulus: fetcher holds fetch_en_in=1 and advances the address by 4 each fetch_rdy_out, over pre-filled lines 0x100..0x10C.
  - Required response: exactly one response per address, in order, 2 cycles apart.
